// File: rtl/lock_pkg.sv
// ============================================================================
// Module      : lock_pkg
// Description : Shared state encoding, password defaults and sizing helper
//               for the combination-lock attempt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lock_pkg;

   localparam int              PW_W       = 6;
   localparam logic [PW_W-1:0] DEFAULT_PW = 6'b101100;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      OPEN    = 3'd2,
      WRONG   = 3'd3,
      LOCKOUT = 3'd4
   } state_t;

   // Width of the shared down-counter, sized for the longest of the three windows
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lock_timer.sv
// ============================================================================
// Module      : lock_timer
// Description : Loadable down-counter that stops at zero and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/lock_attempt_ctrl.sv
// ============================================================================
// Module      : lock_attempt_ctrl
// Description : Code-entry sequencer for the 6-bit combination lock: compare,
//               failure counting, timed open/wrong/lockout windows, reprogram.
//               Optional macro LOCK_ALARM_EN adds a sticky lockout alarm output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_attempt_ctrl #(
   parameter int                  PW_W        = lock_pkg::PW_W,
   parameter logic [PW_W-1:0]     DEFAULT_PW  = lock_pkg::DEFAULT_PW,
   parameter int                  MAX_TRIES   = 3,
   parameter int                  OPEN_CYC    = 500,
   parameter int                  WRONG_CYC   = 50,
   parameter int                  LOCKOUT_CYC = 1000
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           entry_valid,
   input  logic [PW_W-1:0]                entry_code,
   input  logic                           prog_en,
   output logic                           entry_ready,
   output logic                           ledverde,
   output logic                           ledvermelho,
   output logic                           locked_out,
`ifdef LOCK_ALARM_EN
   output logic                           alarm,
`endif
   output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

   import lock_pkg::*;

   localparam int c_FC_W  = $clog2(MAX_TRIES + 1);
   localparam int c_TMR_W = lock_pkg::timer_width(OPEN_CYC, WRONG_CYC, LOCKOUT_CYC);

   localparam logic [c_TMR_W-1:0] c_OPEN_LD    = c_TMR_W'(OPEN_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_WRONG_LD   = c_TMR_W'(WRONG_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_LOCKOUT_LD = c_TMR_W'(LOCKOUT_CYC - 1);
   localparam logic [c_FC_W-1:0]  c_MAX_FAILS  = c_FC_W'(MAX_TRIES);

   state_t             r_state;
   logic [PW_W-1:0]    r_pw;
   logic [PW_W-1:0]    r_code;
   logic [c_FC_W-1:0]  r_fails;

   logic               w_xfer;
   logic               w_match;
   logic [c_FC_W-1:0]  w_fails_next;
   logic               w_load;
   logic [c_TMR_W-1:0] w_load_val;
   logic               w_zero;

   assign entry_ready  = (r_state == IDLE) || ((r_state == OPEN) && prog_en);
   assign w_xfer       = entry_valid && entry_ready;
   assign w_match      = (r_code == r_pw);
   assign w_fails_next = (r_fails == c_MAX_FAILS) ? r_fails : r_fails + 1'b1;

   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         CHECK: begin
            w_load = 1'b1;
            if (w_match)                          w_load_val = c_OPEN_LD;
            else if (w_fails_next == c_MAX_FAILS) w_load_val = c_LOCKOUT_LD;
            else                                  w_load_val = c_WRONG_LD;
         end
         OPEN: begin
            if (w_xfer) begin
               w_load     = 1'b1;
               w_load_val = c_OPEN_LD;
            end
         end
         default: ;
      endcase
   end

   lock_timer #(
      .WIDTH      (c_TMR_W)
   ) u_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_pw    <= DEFAULT_PW;
         r_code  <= '0;
         r_fails <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_code  <= entry_code;
                  r_state <= CHECK;
               end
            end
            CHECK: begin
               if (w_match) begin
                  r_fails <= '0;
                  r_state <= OPEN;
               end else begin
                  r_fails <= w_fails_next;
                  r_state <= (w_fails_next == c_MAX_FAILS) ? LOCKOUT : WRONG;
               end
            end
            // A reprogram landing on the final open cycle keeps the lock open
            OPEN: begin
               if (w_xfer)      r_pw    <= entry_code;
               else if (w_zero) r_state <= IDLE;
            end
            WRONG: begin
               if (w_zero) r_state <= IDLE;
            end
            LOCKOUT: begin
               if (w_zero) begin
                  r_fails <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef LOCK_ALARM_EN
   logic r_alarm;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_alarm <= 1'b0;
      end else if (r_state == CHECK) begin
         if (w_match)                          r_alarm <= 1'b0;
         else if (w_fails_next == c_MAX_FAILS) r_alarm <= 1'b1;
      end
   end

   assign alarm = r_alarm;
`endif

   assign ledverde    = (r_state == OPEN);
   assign ledvermelho = (r_state == WRONG) || (r_state == LOCKOUT);
   assign locked_out  = (r_state == LOCKOUT);
   assign fail_count  = r_fails;

endmodule

`default_nettype wire

// File: tb/tb_lock_attempt_ctrl.sv
// ============================================================================
// Module      : tb_lock_attempt_ctrl
// Description : Self-checking bench for lock_attempt_ctrl with an attempt-level
//               reference model (password, failure count, alarm).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_attempt_ctrl;

   localparam logic [5:0] DEF_PW    = 6'b101100;
   localparam logic [5:0] NEW_PW    = 6'b010011;
   localparam int         MAXT      = 3;
   localparam int         OPEN_N    = 500;
   localparam int         WRONG_N   = 50;
   localparam int         LOCK_N    = 1000;

   logic       clock       = 1'b0;
   logic       reset_n     = 1'b0;
   logic       entry_valid = 1'b0;
   logic       prog_en     = 1'b0;
   logic [5:0] entry_code  = '0;
   wire        entry_ready;
   wire        ledverde;
   wire        ledvermelho;
   wire        locked_out;
   wire  [1:0] fail_count;
`ifdef LOCK_ALARM_EN
   wire        alarm;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] m_pw     = DEF_PW;
   int         m_fails  = 0;
   bit         m_alarm  = 1'b0;

   always #5 clock = ~clock;

   lock_attempt_ctrl dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .entry_valid (entry_valid),
      .entry_code  (entry_code),
      .prog_en     (prog_en),
      .entry_ready (entry_ready),
      .ledverde    (ledverde),
      .ledvermelho (ledvermelho),
      .locked_out  (locked_out),
`ifdef LOCK_ALARM_EN
      .alarm       (alarm),
`endif
      .fail_count  (fail_count)
   );

   // Present one code, then measure the resulting LED window cycle by cycle
   task automatic attempt(input logic [5:0] code, input int prog_at, input logic [5:0] prog_code,
                          output int lat, output int g, output int r, output int lo,
                          output int fc_seen, output int bad);
      int n;
      lat = 0; g = 0; r = 0; lo = 0; bad = 0; fc_seen = -1;
      @(negedge clock);
      n = 0;
      while (!entry_ready && n < 3000) begin
         @(negedge clock);
         n++;
      end
      entry_valid = 1'b1;
      entry_code  = code;
      prog_en     = 1'b0;
      @(posedge clock);
      @(negedge clock);
      entry_valid = 1'b0;
      lat = 1;
      while (!ledverde && !ledvermelho && lat < 10) begin
         @(negedge clock);
         lat++;
      end
      fc_seen = int'(fail_count);
      n = 0;
      while ((ledverde || ledvermelho) && n < 3000) begin
         n++;
         if (ledverde)                   g++;
         if (ledvermelho)                r++;
         if (locked_out)                 lo++;
         if (ledverde && ledvermelho)    bad++;
         if (ledvermelho && entry_ready) bad++;
         if (locked_out && !ledvermelho) bad++;
         entry_valid = 1'b0;
         prog_en     = 1'b0;
         if (ledverde && g == prog_at) begin
            entry_valid = 1'b1;
            prog_en     = 1'b1;
            entry_code  = prog_code;
            #1;
            if (!entry_ready) bad++;
         end else if (ledvermelho) begin
            entry_valid = 1'($urandom_range(0, 1));
            prog_en     = 1'($urandom_range(0, 1));
            entry_code  = 6'($urandom);
         end
         @(negedge clock);
      end
      entry_valid = 1'b0;
      prog_en     = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      m_pw    = DEF_PW;
      m_fails = 0;
      m_alarm = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if ({ledverde, ledvermelho, locked_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_leds: got %b expected 000", {ledverde, ledvermelho, locked_out});
      end
      n_checks++;
      if (fail_count !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_fail_count: got %0d expected 0", fail_count);
      end
`ifdef LOCK_ALARM_EN
      n_checks++;
      if (alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_alarm: got %b expected 0", alarm);
      end
`endif
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++;
      if (entry_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready: got %b expected 1", entry_ready);
      end
   endtask

   task automatic test_open();
      int lat, g, r, lo, fc, bad;
      attempt(DEF_PW, -1, 6'd0, lat, g, r, lo, fc, bad);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL open_latency: got %0d expected 2", lat); end
      n_checks++;
      if (g !== OPEN_N) begin n_fail++; $display("FAIL open_cycles: got %0d expected %0d", g, OPEN_N); end
      n_checks++;
      if (r !== 0 || bad !== 0) begin n_fail++; $display("FAIL open_red_or_bad: got red=%0d bad=%0d expected 0 0", r, bad); end
      n_checks++;
      if ({ledverde, ledvermelho} !== 2'b00 || entry_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL open_return_idle: got leds=%b ready=%b expected 00 1", {ledverde, ledvermelho}, entry_ready);
      end
   endtask

   task automatic test_wrong_then_right();
      int lat, g, r, lo, fc, bad;
      attempt(6'b000000, -1, 6'd0, lat, g, r, lo, fc, bad);
      m_fails = 1;
      n_checks++;
      if (r !== WRONG_N || lo !== 0 || g !== 0) begin
         n_fail++;
         $display("FAIL wrong_window: got red=%0d lock=%0d green=%0d expected %0d 0 0", r, lo, g, WRONG_N);
      end
      n_checks++;
      if (fc !== 1 || fail_count !== 2'd1) begin
         n_fail++;
         $display("FAIL wrong_fail_count: got during=%0d after=%0d expected 1 1", fc, fail_count);
      end
      attempt(DEF_PW, -1, 6'd0, lat, g, r, lo, fc, bad);
      m_fails = 0;
      n_checks++;
      if (g !== OPEN_N || fc !== 0) begin
         n_fail++;
         $display("FAIL right_after_wrong: got green=%0d fc=%0d expected %0d 0", g, fc, OPEN_N);
      end
   endtask

   task automatic test_lockout();
      int lat, g, r, lo, fc, bad;
      for (int i = 1; i <= MAXT; i++) begin
         attempt(~m_pw, -1, 6'd0, lat, g, r, lo, fc, bad);
         n_checks++;
         if (fc !== i) begin n_fail++; $display("FAIL lockout_count_%0d: got %0d expected %0d", i, fc, i); end
      end
      m_fails = 0;
      m_alarm = 1'b1;
      n_checks++;
      if (r !== LOCK_N || lo !== LOCK_N || bad !== 0) begin
         n_fail++;
         $display("FAIL lockout_window: got red=%0d lock=%0d bad=%0d expected %0d %0d 0", r, lo, bad, LOCK_N, LOCK_N);
      end
      n_checks++;
      if (fail_count !== 2'd0 || entry_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL lockout_exit: got fc=%0d ready=%b expected 0 1", fail_count, entry_ready);
      end
`ifdef LOCK_ALARM_EN
      n_checks++;
      if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_after_lockout: got %b expected 1", alarm); end
      attempt(~m_pw, -1, 6'd0, lat, g, r, lo, fc, bad);
      m_fails = 1;
      n_checks++;
      if (alarm !== 1'b1) begin n_fail++; $display("FAIL alarm_sticky_wrong: got %b expected 1", alarm); end
      attempt(m_pw, -1, 6'd0, lat, g, r, lo, fc, bad);
      m_fails = 0;
      m_alarm = 1'b0;
      n_checks++;
      if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_clear_on_match: got %b expected 0", alarm); end
`endif
   endtask

   task automatic test_prog();
      int lat, g, r, lo, fc, bad;
      attempt(m_pw, 100, NEW_PW, lat, g, r, lo, fc, bad);
      m_pw = NEW_PW;
      n_checks++;
      if (g !== 100 + OPEN_N || bad !== 0) begin
         n_fail++;
         $display("FAIL prog_reload: got green=%0d bad=%0d expected %0d 0", g, bad, 100 + OPEN_N);
      end
      attempt(DEF_PW, -1, 6'd0, lat, g, r, lo, fc, bad);
      m_fails = 1;
      n_checks++;
      if (r !== WRONG_N || g !== 0) begin
         n_fail++;
         $display("FAIL prog_old_rejected: got red=%0d green=%0d expected %0d 0", r, g, WRONG_N);
      end
      attempt(NEW_PW, -1, 6'd0, lat, g, r, lo, fc, bad);
      m_fails = 0;
      n_checks++;
      if (g !== OPEN_N || fc !== 0) begin
         n_fail++;
         $display("FAIL prog_new_opens: got green=%0d fc=%0d expected %0d 0", g, fc, OPEN_N);
      end
      do_reset();
      attempt(DEF_PW, -1, 6'd0, lat, g, r, lo, fc, bad);
      n_checks++;
      if (g !== OPEN_N) begin
         n_fail++;
         $display("FAIL reset_restores_pw: got green=%0d expected %0d", g, OPEN_N);
      end
   endtask

   task automatic test_back_to_back();
      int lat, g, r, lo, fc, bad;
      // reprogram exactly on the last open cycle: the transfer must win
      attempt(m_pw, OPEN_N, m_pw, lat, g, r, lo, fc, bad);
      n_checks++;
      if (g !== 2 * OPEN_N || bad !== 0) begin
         n_fail++;
         $display("FAIL last_cycle_reprogram: got green=%0d bad=%0d expected %0d 0", g, bad, 2 * OPEN_N);
      end
   endtask

   task automatic test_reset_mid_lockout();
      int lat, g, r, lo, fc, bad, n;
      while (m_fails < MAXT - 1) begin
         attempt(~m_pw, -1, 6'd0, lat, g, r, lo, fc, bad);
         m_fails++;
      end
      @(negedge clock);
      entry_valid = 1'b1;
      entry_code  = ~m_pw;
      @(negedge clock);
      entry_valid = 1'b0;
      n = 0;
      while (!locked_out && n < 20) begin
         @(negedge clock);
         n++;
      end
      n_checks++;
      if (locked_out !== 1'b1) begin n_fail++; $display("FAIL mid_lockout_entry: got %b expected 1", locked_out); end
      repeat (200) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({locked_out, ledverde, ledvermelho} !== 3'b000 || fail_count !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset: got lock/g/r=%b fc=%0d expected 000 0", {locked_out, ledverde, ledvermelho}, fail_count);
      end
      @(negedge clock);
      reset_n = 1'b1;
      m_pw    = DEF_PW;
      m_fails = 0;
      m_alarm = 1'b0;
   endtask

   task automatic test_random();
      int lat, g, r, lo, fc, bad;
      int exp_g, exp_r, exp_lo, exp_fc, prog_at;
      logic [5:0] code, pc;
      for (int i = 0; i < 12; i++) begin
         code    = ($urandom_range(0, 2) == 0) ? m_pw : 6'($urandom);
         pc      = 6'($urandom);
         prog_at = -1;
         if (code == m_pw && $urandom_range(0, 1) == 1) prog_at = $urandom_range(1, OPEN_N);
         exp_g = 0; exp_r = 0; exp_lo = 0;
         if (code == m_pw) begin
            m_fails = 0;
            m_alarm = 1'b0;
            exp_fc  = 0;
            exp_g   = (prog_at > 0) ? prog_at + OPEN_N : OPEN_N;
         end else begin
            m_fails = m_fails + 1;
            exp_fc  = m_fails;
            if (m_fails == MAXT) begin
               exp_r   = LOCK_N;
               exp_lo  = LOCK_N;
               m_fails = 0;
               m_alarm = 1'b1;
            end else begin
               exp_r = WRONG_N;
            end
         end
         attempt(code, prog_at, pc, lat, g, r, lo, fc, bad);
         if (code == m_pw && prog_at > 0 && exp_fc == 0 && exp_g > OPEN_N) m_pw = pc;
         n_checks++;
         if (lat !== 2 || g !== exp_g || r !== exp_r || lo !== exp_lo || fc !== exp_fc || bad !== 0) begin
            n_fail++;
            $display("FAIL random_%0d: got lat=%0d g=%0d r=%0d lo=%0d fc=%0d bad=%0d expected 2 %0d %0d %0d %0d 0",
                     i, lat, g, r, lo, fc, bad, exp_g, exp_r, exp_lo, exp_fc);
         end
         n_checks++;
         if (int'(fail_count) !== m_fails) begin
            n_fail++;
            $display("FAIL random_%0d_fc_after: got %0d expected %0d", i, fail_count, m_fails);
         end
`ifdef LOCK_ALARM_EN
         n_checks++;
         if (alarm !== m_alarm) begin
            n_fail++;
            $display("FAIL random_%0d_alarm: got %b expected %b", i, alarm, m_alarm);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_open();
      test_wrong_then_right();
      test_lockout();
      test_prog();
      test_back_to_back();
      test_reset_mid_lockout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
